// File: rtl/mem_port_arbiter.sv
// Merges the core's instruction-fetch and data ports onto one memory port, one transaction at a time.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both ports request together (default: data first).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_read,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_resp,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_read,
  input  logic                data_write,
  input  logic [DATA_W/8-1:0] data_mbe,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_resp,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_mbe,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MBE_W = DATA_W / 8;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BUSY_I = 3'd1;
  localparam logic [2:0] BUSY_D = 3'd2;
  localparam logic [2:0] RESP_I = 3'd3;
  localparam logic [2:0] RESP_D = 3'd4;

  logic [2:0]        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MBE_W-1:0]  mbe_q;
  logic              wr_q;
  logic [DATA_W-1:0] inst_rdata_q;
  logic [DATA_W-1:0] data_rdata_q;
  logic              data_req;
  logic              pick_data;
  logic              busy;

  assign data_req = data_read | data_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_data_q = 1 when the data port won the previous arbitration
  logic last_data_q;

  assign pick_data = data_req & (~inst_read | ~last_data_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_data_q <= 1'b0;
    end else if (state_q == IDLE && (data_req || inst_read)) begin
      last_data_q <= pick_data;
    end
  end
`else
  assign pick_data = data_req;
`endif

  // Arbitration, request latch and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      mbe_q        <= '0;
      wr_q         <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_data) begin
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
            mbe_q   <= data_mbe;
            wr_q    <= data_write;
            state_q <= BUSY_D;
          end else if (inst_read) begin
            addr_q  <= inst_addr;
            wdata_q <= '0;
            mbe_q   <= '1;
            wr_q    <= 1'b0;
            state_q <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (mem_resp) begin
            inst_rdata_q <= mem_rdata;
            state_q      <= RESP_I;
          end
        end
        BUSY_D: begin
          if (mem_resp) begin
            data_rdata_q <= wr_q ? '0 : mem_rdata;
            state_q      <= RESP_D;
          end
        end
        RESP_I, RESP_D: state_q <= IDLE;
        default:        state_q <= IDLE;
      endcase
    end
  end

  // Memory side is driven purely from the latched request
  assign busy      = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign mem_read  = busy & ~wr_q;
  assign mem_write = busy & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_mbe   = mbe_q;

  assign inst_resp  = (state_q == RESP_I);
  assign data_resp  = (state_q == RESP_D);
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses queued at request time, popped on resp pulses.
module tb_mem_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MBE_W  = DATA_W / 8;

  logic              clk;
  logic              rst;
  logic              inst_read;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_resp;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_read;
  logic              data_write;
  logic [MBE_W-1:0]  data_mbe;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_resp;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MBE_W-1:0]  mem_mbe;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_read  (inst_read),
    .inst_addr  (inst_addr),
    .inst_resp  (inst_resp),
    .inst_rdata (inst_rdata),
    .data_read  (data_read),
    .data_write (data_write),
    .data_mbe   (data_mbe),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_resp  (data_resp),
    .data_rdata (data_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_mbe    (mem_mbe),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata)
  );

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_chk = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Response monitor: every resp pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (inst_resp && data_resp) begin
      chk("both_resp", 1, 0);
    end else if (inst_resp || data_resp) begin
      if (exp_q.size() == 0) begin
        chk("unexp_resp", {inst_resp, data_resp}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", data_resp, e.is_data);
        chk("resp_rdata", data_resp ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  // Memory model: waits for a strobe, checks held fields for lat cycles, then responds
  task automatic serve_mem(input logic exp_wr, input logic [31:0] exp_addr,
                           input logic [31:0] exp_wdata, input logic [3:0] exp_mbe,
                           input logic [31:0] rdata, input int lat, input bit perturb,
                           input int exp_wait);
    bit found = 0;
    int waited = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found  = mem_read | mem_write;
      waited = i;
    end
    chk("mem_req_seen", found, 1);
    if (found) begin
      chk("req_latency", waited, exp_wait);
      for (int k = 1; k <= lat; k++) begin
        chk("mem_read", mem_read, !exp_wr);
        chk("mem_write", mem_write, exp_wr);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_mbe", mem_mbe, exp_mbe);
        if (exp_wr) chk("mem_wdata", mem_wdata, exp_wdata);
        if (perturb && k == 1) data_addr = 32'h300;
        if (k < lat) @(negedge clk);
      end
      mem_resp  = 1'b1;
      mem_rdata = rdata;
      @(posedge clk);
      #1;
      mem_resp  = 1'b0;
      mem_rdata = 32'hA5A5_5A5A;
    end
  endtask

  // After the mem_resp edge: one resp cycle with strobes low, then an idle cycle with no resp
  task automatic fin_txn();
    @(negedge clk);
    chk("resp_latency", inst_resp | data_resp, 1);
    chk("strobe_off", {mem_read, mem_write}, 0);
    @(negedge clk);
    chk("resp_once", {inst_resp, data_resp}, 0);
  endtask

  initial begin
    bit found;
    rst        = 1'b0;
    inst_read  = 1'b0;
    inst_addr  = '0;
    data_read  = 1'b0;
    data_write = 1'b0;
    data_mbe   = '0;
    data_addr  = '0;
    data_wdata = '0;
    mem_resp   = 1'b0;
    mem_rdata  = '0;
    #12;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_resp", {inst_resp, data_resp}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single fetch, memory answers after 2 cycles
    @(posedge clk); #1;
    inst_read = 1'b1; inst_addr = 32'h60;
    exp_q.push_back('{1'b0, 32'h0000_0013});
    serve_mem(1'b0, 32'h60, 32'h0, 4'hF, 32'h0000_0013, 2, 1'b0, 1);
    inst_read = 1'b0;
    fin_txn();
    chk("inst_rdata_hold", inst_rdata, 32'h0000_0013);

    // Store with one-cycle memory
    @(posedge clk); #1;
    data_write = 1'b1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; data_mbe = 4'h3;
    exp_q.push_back('{1'b1, 32'h0});
    serve_mem(1'b1, 32'h100, 32'hDEAD_BEEF, 4'h3, 32'h55AA_55AA, 1, 1'b0, 1);
    data_write = 1'b0;
    fin_txn();

    // Both ports request together
    @(posedge clk); #1;
    inst_read = 1'b1; inst_addr = 32'h64;
    data_read = 1'b1; data_addr = 32'h200; data_mbe = 4'hF;
`ifdef ARB_ROUND_ROBIN_EN
    exp_q.push_back('{1'b0, 32'h1111_1111});
    exp_q.push_back('{1'b1, 32'h2222_2222});
    serve_mem(1'b0, 32'h64, 32'h0, 4'hF, 32'h1111_1111, 1, 1'b0, 1);
    inst_read = 1'b0;
    fin_txn();
    serve_mem(1'b0, 32'h200, 32'h0, 4'hF, 32'h2222_2222, 1, 1'b0, 0);
    data_read = 1'b0;
    fin_txn();
`else
    exp_q.push_back('{1'b1, 32'h2222_2222});
    exp_q.push_back('{1'b0, 32'h1111_1111});
    serve_mem(1'b0, 32'h200, 32'h0, 4'hF, 32'h2222_2222, 1, 1'b0, 1);
    data_read = 1'b0;
    fin_txn();
    serve_mem(1'b0, 32'h64, 32'h0, 4'hF, 32'h1111_1111, 1, 1'b0, 0);
    inst_read = 1'b0;
    fin_txn();
`endif

    // Requester address changes mid-transaction; memory side must hold the latched value
    @(posedge clk); #1;
    data_read = 1'b1; data_addr = 32'h200; data_mbe = 4'hC;
    exp_q.push_back('{1'b1, 32'hCAFE_F00D});
    serve_mem(1'b0, 32'h200, 32'h0, 4'hC, 32'hCAFE_F00D, 3, 1'b1, 1);
    data_read = 1'b0;
    fin_txn();

    // Read and write together: single write transaction
    @(posedge clk); #1;
    data_read = 1'b1; data_write = 1'b1;
    data_addr = 32'h180; data_wdata = 32'h1234_5678; data_mbe = 4'hF;
    exp_q.push_back('{1'b1, 32'h0});
    serve_mem(1'b1, 32'h180, 32'h1234_5678, 4'hF, 32'hFFFF_0000, 1, 1'b0, 1);
    data_read = 1'b0; data_write = 1'b0;
    fin_txn();

    // Asynchronous reset in the middle of a fetch
    @(posedge clk); #1;
    inst_read = 1'b1; inst_addr = 32'h80;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = mem_read;
    end
    chk("rst_fetch_seen", found, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_mem_read", mem_read, 0);
    chk("async_resp", {inst_resp, data_resp}, 0);
    chk("async_mem_addr", mem_addr, 0);
    chk("async_inst_rdata", inst_rdata, 0);
    inst_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    mem_resp = 1'b1; mem_rdata = 32'h0000_0BAD;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_resp", {inst_resp, data_resp}, 0);
      chk("post_rst_strobe", {mem_read, mem_write}, 0);
    end

    // Stray mem_resp while idle, then a normal fetch still works
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = 32'h0000_0DEF;
    @(posedge clk); #1;
    mem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stray_resp", {inst_resp, data_resp}, 0);
      chk("stray_strobe", {mem_read, mem_write}, 0);
    end
    @(posedge clk); #1;
    inst_read = 1'b1; inst_addr = 32'h40;
    exp_q.push_back('{1'b0, 32'h0000_0077});
    serve_mem(1'b0, 32'h40, 32'h0, 4'hF, 32'h0000_0077, 1, 1'b0, 1);
    inst_read = 1'b0;
    fin_txn();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipelined CPU core.
- Merges the core's instruction-fetch port (inst_*) and data port (data_*) onto one memory/cache port (mem_*).
- Arbitrates, latches the winning request, holds it stable until the memory responds, then returns a registered response to the winner.
- Serves one transaction at a time; no outstanding-request overlap.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports; byte-enable width is DATA_W/8

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
inst_read  in  1  fetch request, held high until inst_resp
inst_addr  in  ADDR_W  fetch address
inst_resp  out  1  one-cycle fetch completion pulse
inst_rdata  out  DATA_W  fetch data, valid while inst_resp=1
data_read  in  1  load request, held until data_resp
data_write  in  1  store request, held until data_resp
data_mbe  in  DATA_W/8  store byte enables
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_resp  out  1  one-cycle load/store completion pulse
data_rdata  out  DATA_W  load data, valid while data_resp=1
mem_read  out  1  downstream read strobe
mem_write  out  1  downstream write strobe
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data
mem_mbe  out  DATA_W/8  downstream byte enables
mem_resp  in  1  downstream completion, one cycle
mem_rdata  in  DATA_W  downstream read data, valid with mem_resp

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0 immediately, including mem_read/mem_write and any in-flight response.
  - Internal latches clear.
  - An in-flight transaction is abandoned; nothing is replayed after reset release.
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - If data_read|data_write: latch data_addr/data_wdata/data_mbe and the op, go to BUSY_D.
  - Else if inst_read: latch inst_addr, set mbe to all ones and op to read, go to BUSY_I.
  - Else stay in IDLE.
  - Default priority is fixed: data over instruction.
- BUSY_x:
  - mem_read/mem_write, mem_addr, mem_wdata and mem_mbe are driven only from the latched registers.
  - They stay constant for the whole state, even if the requester's inputs change.
  - On mem_resp=1: capture mem_rdata, go to RESP_x. Otherwise hold.
- RESP_x:
  - Assert the winner's *_resp for exactly one cycle; its *_rdata equals the captured word.
  - mem strobes are 0.
  - Next state is IDLE.
  - For writes, data_rdata is don't-care and is driven 0.
- Latency:
  - Request sampled in IDLE at edge N drives the mem strobe from cycle N+1.
  - mem_resp at edge M drives *_resp in cycle M+1.
  - Minimum round trip is 3 cycles when memory responds in 1 cycle.
- Arbitration happens in IDLE only; there is at least one IDLE cycle between transactions.
- A request still high in the IDLE cycle following its RESP is treated as a new request. The core drops its strobe on seeing resp.
- data_read and data_write both 1: write wins, single transaction, mem_read stays 0.
- mem_resp while in IDLE or RESP_x: ignored.
- *_rdata outputs hold their last value outside resp cycles; they are not cleared.
- inst_resp and data_resp are never high in the same cycle.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined:
  - A 1-bit last-grant register (reset value = instruction) is added.
  - When both ports request in IDLE, the port not granted last wins; a single requester always wins.
  - last-grant updates on entry to BUSY_x.
- Undefined: fixed data-over-instruction priority as above; no extra state.

Test Plan:
- Single fetch: inst_read=1, inst_addr=0x60, mem_resp after 2 cycles with mem_rdata=0x00000013 -> mem_read=1, mem_addr=0x60, mem_mbe=0xF; inst_resp pulses 1 cycle with inst_rdata=0x00000013; mem_write never 1.
- Store: data_write=1, addr 0x100, wdata 0xDEADBEEF, mbe 0x3, one-cycle mem_resp -> mem_write=1 with identical fields; data_resp pulses once; inst_resp stays 0.
- Simultaneous inst_read (0x64) and data_read (0x200), macro off -> data served first, inst second, each with one resp pulse. Macro on, after a prior data grant -> inst served first.
- Input perturbation: change data_addr to 0x300 mid-BUSY_D -> mem_addr stays at the latched 0x200 until mem_resp.
- Reset mid-BUSY_I with mem_read=1: assert rst=0 -> mem_read=0 and all resp=0 without a clock edge. After release, IDLE with no resp pulse; a late mem_resp is ignored.
- Stray mem_resp=1 in IDLE with no requests -> no resp pulse, state stays IDLE.
